// File: rtl/cnn_conv_pool_engine.sv
// Convolution + max-pool engine: loads NUM_KERNELS signed kernels from kernel memory,
// then computes ReLU/shift/saturated dot products per window and max-pools over POOL_N windows.
module cnn_conv_pool_engine #(
    parameter int NUM_KERNELS = 2,
    parameter int TAPS        = 4,
    parameter int PIX_W       = 8,
    parameter int ADDR_W      = 5,
    parameter int KBASE       = 0,
    parameter int SHIFT       = 2,
    parameter int POOL_N      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    output logic                         busy,
    output logic                         kmem_rd_en,
    output logic [ADDR_W-1:0]            kmem_addr,
    input  logic [TAPS*PIX_W-1:0]        kmem_rdata,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [TAPS*PIX_W-1:0]        pix_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_KERNELS*PIX_W-1:0] out_data
);

    localparam int ACC_W  = 2*PIX_W + $clog2(TAPS) + 1;
    localparam int KIDX_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
    localparam int CNT_W  = (POOL_N > 1) ? $clog2(POOL_N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;

    state_t                state, state_next;
    logic [KIDX_W-1:0]     rd_idx;
    logic                  cap_en;
    logic [KIDX_W-1:0]     cap_idx;
    logic [TAPS*PIX_W-1:0] kern [NUM_KERNELS];
    logic                  kern_valid;
    logic [CNT_W-1:0]      pool_cnt;
    logic [PIX_W-1:0]      pool_max [NUM_KERNELS];
    logic [PIX_W-1:0]      win_val  [NUM_KERNELS];
    logic [PIX_W-1:0]      new_max  [NUM_KERNELS];
    logic                  last_rd, reload, accept, pool_first, pool_last;

    assign last_rd    = (rd_idx == KIDX_W'(NUM_KERNELS-1));
    assign reload     = (state == RUN) && load_start;
    assign pix_ready  = (state == RUN) && kern_valid && (!out_valid || out_ready);
    assign accept     = pix_valid && pix_ready;
    assign pool_first = (pool_cnt == '0);
    assign pool_last  = (pool_cnt == CNT_W'(POOL_N-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        kmem_rd_en = 1'b0;
        kmem_addr  = '0;
        case (state)
            IDLE: begin
                if (load_start) state_next = LOAD;
            end
            LOAD: begin
                kmem_rd_en = 1'b1;
                kmem_addr  = ADDR_W'(KBASE) + ADDR_W'(rd_idx);
                if (last_rd) state_next = DRAIN;
            end
            DRAIN: begin
                state_next = RUN;
            end
            RUN: begin
                busy = 1'b0;
                if (load_start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data arrives one cycle after the strobe, so the capture index trails rd_idx by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx     <= '0;
            cap_en     <= 1'b0;
            cap_idx    <= '0;
            kern_valid <= 1'b0;
        end else begin
            cap_en  <= (state == LOAD);
            cap_idx <= rd_idx;
            if (state == LOAD) begin
                rd_idx <= last_rd ? '0 : rd_idx + KIDX_W'(1);
            end
            if (reload) begin
                kern_valid <= 1'b0;
            end else if (state == DRAIN) begin
                kern_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            kern[cap_idx] <= kmem_rdata;
        end
    end

    always_comb begin
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] w_ext;
        logic signed [ACC_W-1:0] p_ext;
        logic        [ACC_W-1:0] shifted;
        logic        [PIX_W-1:0] w;
        logic        [PIX_W-1:0] p;
        acc     = '0;
        w_ext   = '0;
        p_ext   = '0;
        shifted = '0;
        w       = '0;
        p       = '0;
        for (int k = 0; k < NUM_KERNELS; k++) begin
            acc = '0;
            for (int i = 0; i < TAPS; i++) begin
                w     = kern[k][i*PIX_W +: PIX_W];
                p     = pix_data[i*PIX_W +: PIX_W];
                w_ext = {{(ACC_W-PIX_W){w[PIX_W-1]}}, w};
                p_ext = {{(ACC_W-PIX_W){1'b0}}, p};
                acc   = acc + w_ext * p_ext;
            end
            shifted    = acc[ACC_W-1] ? '0 : (ACC_W'(acc) >> SHIFT);
            win_val[k] = (|shifted[ACC_W-1:PIX_W]) ? '1 : shifted[PIX_W-1:0];
            new_max[k] = (pool_first || (win_val[k] > pool_max[k])) ? win_val[k] : pool_max[k];
        end
    end

    // A reload restarts pooling but leaves an unaccepted result in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            pool_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < NUM_KERNELS; k++) pool_max[k] <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (reload) begin
                pool_cnt <= '0;
                for (int k = 0; k < NUM_KERNELS; k++) pool_max[k] <= '0;
            end else if (accept) begin
                for (int k = 0; k < NUM_KERNELS; k++) pool_max[k] <= new_max[k];
                if (pool_last) begin
                    pool_cnt  <= '0;
                    out_valid <= 1'b1;
                    for (int k = 0; k < NUM_KERNELS; k++) out_data[k*PIX_W +: PIX_W] <= new_max[k];
                end else begin
                    pool_cnt <= pool_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_conv_pool_engine.sv
// Bench for cnn_conv_pool_engine: directed vector table, multi-cycle corner cases and a
// randomized phase checked every cycle against an arithmetic reference model.
module tb_cnn_conv_pool_engine;

    localparam int K     = 2;
    localparam int T     = 4;
    localparam int PW    = 8;
    localparam int AW    = 5;
    localparam int KBASE = 0;
    localparam int SH    = 2;
    localparam int POOL  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_start;
    logic            busy;
    logic            kmem_rd_en;
    logic [AW-1:0]   kmem_addr;
    logic [T*PW-1:0] kmem_rdata;
    logic            pix_valid;
    logic            pix_ready;
    logic [T*PW-1:0] pix_data;
    logic            out_valid;
    logic            out_ready;
    logic [K*PW-1:0] out_data;

    logic [T*PW-1:0] mem [2**AW];

    int tests = 0;
    int fails = 0;
    int n_results = 0;

    bit              mon_en = 1'b0;
    bit              m_run = 1'b0;
    int              m_left = 0;
    bit              m_valid = 1'b0;
    logic [K*PW-1:0] m_front = '0;
    int              g_cnt = 0;
    int              g_max [K];
    logic [T*PW-1:0] m_w [K];

    typedef struct {
        string        name;
        logic [31:0]  kern0;
        logic [31:0]  kern1;
        logic [127:0] wins;
        logic [15:0]  expected;
    } vec_t;

    vec_t vecs [3];

    cnn_conv_pool_engine #(
        .NUM_KERNELS(K), .TAPS(T), .PIX_W(PW), .ADDR_W(AW),
        .KBASE(KBASE), .SHIFT(SH), .POOL_N(POOL)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .busy(busy),
        .kmem_rd_en(kmem_rd_en), .kmem_addr(kmem_addr), .kmem_rdata(kmem_rdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (kmem_rd_en) kmem_rdata <= mem[kmem_addr];
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int win_value(input int k, input logic [31:0] win);
        int acc = 0;
        logic signed [7:0] w;
        logic [7:0] p;
        for (int i = 0; i < T; i++) begin
            w = m_w[k][i*8 +: 8];
            p = win[i*8 +: 8];
            acc += int'(w) * int'(p);
        end
        if (acc < 0) acc = 0;
        acc = acc / (1 << SH);
        if (acc > 255) acc = 255;
        return acc;
    endfunction

    // Reference model: compare at mid-cycle, then advance by what the coming edge will commit.
    always @(negedge clk) begin
        bit exp_ready;
        int v;
        if (mon_en) begin
            exp_ready = m_run && (!m_valid || out_ready);
            check_output("mon_busy", busy, !m_run);
            check_output("mon_pix_ready", pix_ready, exp_ready);
            check_output("mon_out_valid", out_valid, m_valid);
            if (m_valid) check_output("mon_out_data", out_data, m_front);
        end
        if (rst) begin
            m_run = 1'b0; m_left = 0; m_valid = 1'b0; g_cnt = 0;
        end else begin
            exp_ready = m_run && (!m_valid || out_ready);
            if (m_valid && out_ready) begin
                m_valid = 1'b0;
                n_results++;
            end
            if (load_start && m_left == 0) begin
                m_run = 1'b0;
                m_left = K + 1;
                for (int k = 0; k < K; k++) m_w[k] = mem[KBASE + k];
                g_cnt = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_run = 1'b1;
            end else if (pix_valid && exp_ready) begin
                for (int k = 0; k < K; k++) begin
                    v = win_value(k, pix_data);
                    g_max[k] = (g_cnt == 0 || v > g_max[k]) ? v : g_max[k];
                end
                g_cnt++;
                if (g_cnt == POOL) begin
                    g_cnt = 0;
                    m_valid = 1'b1;
                    for (int k = 0; k < K; k++) m_front[k*8 +: 8] = 8'(g_max[k]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        int n = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check_output("load_done", busy, 1'b0);
    endtask

    // Presents one window and returns just after the edge that accepts it.
    task automatic apply_stimulus(input logic [31:0] win);
        int n = 0;
        pix_data  = win;
        pix_valid = 1'b1;
        #1;
        while (!pix_ready && n < 50) begin
            tick();
            n++;
        end
        if (!pix_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: pix_ready stayed 0, expected 1");
        end
        tick();
        pix_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"vec_basic", 32'h01010101, 32'h010000FF,
                    {32'h0A141E28, 32'h04040404, 32'h00000000, 32'h281E140A}, 16'h0719};
        vecs[1] = '{"vec_saturate", 32'h7F7F7F7F, 32'h010000FF,
                    {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 16'h00FF};
        vecs[2] = '{"vec_mixed", 32'hFD03FE02, 32'h01000000,
                    {32'hFFFF00FF, 32'h08080808, 32'h00006400, 32'h00320064}, 16'h3F7F};

        rst = 1'b1; load_start = 1'b0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
        for (int a = 0; a < 2**AW; a++) mem[a] = '0;
        mem[0] = 32'h01010101;
        mem[1] = 32'h010000FF;
        tick();
        tick();
        mon_en = 1'b1;
        tick();
        check_output("rst_busy", busy, 1'b1);
        check_output("rst_rd_en", kmem_rd_en, 1'b0);
        check_output("rst_addr", kmem_addr, 0);
        check_output("rst_pix_ready", pix_ready, 1'b0);
        check_output("rst_out_valid", out_valid, 1'b0);
        check_output("rst_out_data", out_data, 0);
        rst = 1'b0;
        tick();

        // Load sequence timing
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check_output("t1_rd0_en", kmem_rd_en, 1'b1);
        check_output("t1_rd0_addr", kmem_addr, 0);
        tick();
        check_output("t1_rd1_en", kmem_rd_en, 1'b1);
        check_output("t1_rd1_addr", kmem_addr, 1);
        tick();
        check_output("t1_drain_rd_en", kmem_rd_en, 1'b0);
        check_output("t1_drain_busy", busy, 1'b1);
        tick();
        check_output("t1_run_busy", busy, 1'b0);
        check_output("t1_run_pix_ready", pix_ready, 1'b1);

        for (int v = 0; v < 3; v++) begin
            mem[0] = vecs[v].kern0;
            mem[1] = vecs[v].kern1;
            do_load();
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) apply_stimulus(vecs[v].wins[i*32 +: 32]);
            check_output({vecs[v].name, "_valid"}, out_valid, 1'b1);
            check_output({vecs[v].name, "_data"}, out_data, vecs[v].expected);
            tick();
        end

        // Backpressure hold, then simultaneous result and window handshakes
        for (int i = 0; i < 3; i++) apply_stimulus(vecs[2].wins[i*32 +: 32]);
        out_ready = 1'b0;
        apply_stimulus(vecs[2].wins[96 +: 32]);
        pix_valid = 1'b1;
        pix_data  = 32'h11223344;
        for (int c = 0; c < 10; c++) begin
            check_output("t4_hold_pix_ready", pix_ready, 1'b0);
            check_output("t4_hold_data", out_data, 16'h3F7F);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_output("t4_release_pix_ready", pix_ready, 1'b1);
        tick();
        pix_valid = 1'b0;
        check_output("t4_release_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus($urandom);
        tick();

        // load_start during LOAD is ignored; reload in RUN discards a partial group
        mem[0] = 32'h01010101;
        mem[1] = 32'h010000FF;
        load_start = 1'b1;
        tick();
        tick();
        load_start = 1'b0;
        check_output("t5_busy_e1", busy, 1'b1);
        tick();
        check_output("t5_busy_e2", busy, 1'b1);
        tick();
        check_output("t5_busy_e3", busy, 1'b0);
        apply_stimulus(32'hFFFFFFFF);
        apply_stimulus(32'hFFFFFFFF);
        do_load();
        for (int i = 0; i < 4; i++) apply_stimulus(32'h01010101);
        check_output("t5_fresh_valid", out_valid, 1'b1);
        check_output("t5_fresh_data", out_data, 16'h0001);
        tick();

        // Reset during DRAIN aborts the load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("t6_busy", busy, 1'b1);
        check_output("t6_pix_ready", pix_ready, 1'b0);
        check_output("t6_out_valid", out_valid, 1'b0);
        pix_valid = 1'b1;
        pix_data  = 32'h55555555;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_output("t6_no_result", out_valid, 1'b0);
        end
        pix_valid = 1'b0;

        // Randomized traffic with occasional reloads of random kernels
        mem[0] = $urandom;
        mem[1] = $urandom;
        do_load();
        for (int c = 0; c < 3000; c++) begin
            if (!busy && $urandom_range(0, 99) == 0) begin
                mem[0] = $urandom;
                mem[1] = $urandom;
                load_start = 1'b1;
                pix_valid  = 1'b0;
            end else begin
                load_start = 1'b0;
                pix_valid  = ($urandom_range(0, 3) != 0);
                pix_data   = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        load_start = 1'b0;
        pix_valid  = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        check_output("rand_results_seen", n_results > 50, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
